// File: rtl/mux_scan_seq_if.sv
// Bundle of control, mux and frame signals between the scan sequencer and its environment.
interface mux_scan_seq_if;
    localparam int unsigned NCH  = 4;
    localparam int unsigned CH_W = 2;

    logic            start;
    logic            stop;
    logic            cont;
    logic [NCH-1:0]  mask;
    logic            mux_y;
    logic            mux_en;
    logic [CH_W-1:0] mux_s;
    logic            busy;
    logic [NCH-1:0]  frame;
    logic            frame_valid;

    modport master (
        input  start, stop, cont, mask, mux_y,
        output mux_en, mux_s, busy, frame, frame_valid
    );

    modport slave (
        output start, stop, cont, mask, mux_y,
        input  mux_en, mux_s, busy, frame, frame_valid
    );
endinterface

// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 4:1 single-bit mux: dwells on each enabled channel, samples
// the mux output on the last dwell cycle and publishes the packed frame.
module mux_scan_seq #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_scan_seq_if.master bus
);
    localparam int unsigned NCH  = 4;
    localparam int unsigned CH_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state,       state_n;
    logic            mux_en_r,    mux_en_n;
    logic [CH_W-1:0] ch_r,        ch_n;
    logic            busy_r,      busy_n;
    logic [NCH-1:0]  frame_r,     frame_n;
    logic            valid_r,     valid_n;
    logic [CNT_W-1:0] counter,    counter_n;
    logic [NCH-1:0]  shadow,      shadow_n;
    logic [NCH-1:0]  mask_r,      mask_n;
    logic            cont_r,      cont_n;
    logic            launch;
    logic [CH_W:0]   nxt_ch;
    logic [CH_W:0]   first_ch;

    // Lowest set channel at or above 'from'; MSB of the result flags that one was found.
    function automatic logic [CH_W:0] find_ch(input logic [NCH-1:0] m, input logic [CH_W:0] from);
        find_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && ((CH_W + 1)'(i) >= from)) begin
                find_ch = {1'b1, CH_W'(i)};
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mux_en_r <= 1'b0;
            ch_r     <= '0;
            busy_r   <= 1'b0;
            frame_r  <= '0;
            valid_r  <= 1'b0;
            counter  <= '0;
            shadow   <= '0;
            mask_r   <= '0;
            cont_r   <= 1'b0;
        end else begin
            state    <= state_n;
            mux_en_r <= mux_en_n;
            ch_r     <= ch_n;
            busy_r   <= busy_n;
            frame_r  <= frame_n;
            valid_r  <= valid_n;
            counter  <= counter_n;
            shadow   <= shadow_n;
            mask_r   <= mask_n;
            cont_r   <= cont_n;
        end
    end

    always_comb begin
        state_n   = state;
        mux_en_n  = mux_en_r;
        ch_n      = ch_r;
        frame_n   = frame_r;
        valid_n   = 1'b0;
        counter_n = counter;
        shadow_n  = shadow;
        mask_n    = mask_r;
        cont_n    = cont_r;
        launch    = 1'b0;
        nxt_ch    = find_ch(mask_r, {1'b0, ch_r} + (CH_W + 1)'(1));
        first_ch  = find_ch(bus.mask, '0);

        case (state)
            IDLE: begin
                if (!bus.stop && bus.start) begin
                    launch = 1'b1;
                end
            end
            DRIVE: begin
                if (bus.stop) begin
                    state_n  = IDLE;
                    mux_en_n = 1'b0;
                    shadow_n = '0;
                end else if (counter == '0) begin
                    if (nxt_ch[CH_W]) begin
                        shadow_n[ch_r] = bus.mux_y;
                        ch_n           = nxt_ch[CH_W-1:0];
                        counter_n      = CNT_LOAD;
                    end else begin
                        // Last channel: publish directly so the final sample is not a cycle late.
                        state_n        = DONE;
                        mux_en_n       = 1'b0;
                        frame_n        = shadow;
                        frame_n[ch_r]  = bus.mux_y;
                        valid_n        = 1'b1;
                    end
                end else begin
                    counter_n = counter - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_n  = IDLE;
                    shadow_n = '0;
                end else if (cont_r) begin
                    launch = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n  = IDLE;
                mux_en_n = 1'b0;
            end
        endcase

        // Frame start, shared by IDLE+start and continuous restart from DONE.
        if (launch) begin
            mask_n   = bus.mask;
            cont_n   = bus.cont;
            shadow_n = '0;
            if (first_ch[CH_W]) begin
                state_n   = DRIVE;
                mux_en_n  = 1'b1;
                ch_n      = first_ch[CH_W-1:0];
                counter_n = CNT_LOAD;
            end else begin
                state_n  = DONE;
                mux_en_n = 1'b0;
                frame_n  = '0;
                valid_n  = 1'b1;
            end
        end

        busy_n = (state_n != IDLE);
    end

    assign bus.mux_en      = mux_en_r;
    assign bus.mux_s       = ch_r;
    assign bus.busy        = busy_r;
    assign bus.frame       = frame_r;
    assign bus.frame_valid = valid_r;
endmodule
